// File: rtl/multiply_tokens_pkg.sv
// Shared types and helpers for the serial token multiplier.
//   PEND_W   width of a per-lane pending counter, sized for DEF_MAX_PENDING
//   pend_t   pending counter type
//   wide_t   counter plus one guard bit so that add/take cannot wrap
//   lane_in_t / lane_out_t   per-lane request/response bundles
//   next_count()  pending + add - take at wide_t width
//   over_limit()  true when a wide count exceeds the legal maximum
package multiply_tokens_pkg;

  localparam int unsigned DEF_MAX_PENDING = 255;
  localparam int unsigned PEND_W          = $clog2(DEF_MAX_PENDING + 1);

  typedef logic [PEND_W-1:0] pend_t;
  typedef logic [PEND_W:0]   wide_t;

  typedef struct packed {
    logic a;
    logic b_ready;
  } lane_in_t;

  typedef struct packed {
    logic b;
    logic ovf;
  } lane_out_t;

  // take is only ever 1 when p != 0, so the subtraction cannot go negative.
  function automatic wide_t next_count(pend_t p, wide_t add, logic take);
    return wide_t'(p) + add - wide_t'(take);
  endfunction

  function automatic logic over_limit(wide_t n, int unsigned max_pending);
    return n > wide_t'(max_pending);
  endfunction

endpackage

// File: rtl/multiply_tokens_if.sv
// Token bus between sources/consumers and the multiplier.
//   factor    shared multiplication factor
//   a         input token per lane
//   b         output token offered per lane
//   b_ready   downstream accept per lane
//   overflow  sticky per-lane error
//   any_ovf   registered OR of overflow
// master = the side driving tokens in (source/consumer harness),
// slave  = the multiplier.
interface multiply_tokens_if #(
  parameter int LANES    = 4,
  parameter int FACTOR_W = 3
) ();

  logic [FACTOR_W-1:0] factor;
  logic [LANES-1:0]    a;
  logic [LANES-1:0]    b;
  logic [LANES-1:0]    b_ready;
  logic [LANES-1:0]    overflow;
  logic                any_ovf;

  modport master (
    output factor, a, b_ready,
    input  b, overflow, any_ovf
  );

  modport slave (
    input  factor, a, b_ready,
    output b, overflow, any_ovf
  );

endinterface

// File: rtl/multiply_tokens_lane.sv
// One token lane: pending counter, registered output token, sticky overflow.
//   clk, rst   clock / synchronous active-high reset
//   factor     tokens added per input token
//   din        {a, b_ready} for this lane
//   dout       {b, ovf} for this lane, both registered
// Once ovf is set the lane ignores all inputs and offers nothing until rst.
module multiply_tokens_lane
  import multiply_tokens_pkg::*;
#(
  parameter int FACTOR_W    = 3,
  parameter int MAX_PENDING = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FACTOR_W-1:0] factor,
  input  lane_in_t            din,
  output lane_out_t           dout
);

  pend_t pending;
  logic  b_q;
  logic  ovf_q;
  logic  take;
  wide_t add;
  wide_t nxt;

  // b_q mirrors (pending != 0); gating with it keeps an X on b_ready from
  // reaching the counter while nothing is offered.
  always_comb begin
    take = b_q & din.b_ready;
    add  = din.a ? wide_t'(factor) : '0;
    nxt  = next_count(pending, add, take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      b_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!ovf_q) begin
      if (over_limit(nxt, MAX_PENDING)) begin
        ovf_q   <= 1'b1;
        pending <= '0;
        b_q     <= 1'b0;
      end else begin
        pending <= pend_t'(nxt);
        b_q     <= (nxt != '0);
      end
    end
  end

  assign dout.b   = b_q;
  assign dout.ovf = ovf_q;

endmodule

// File: rtl/multiply_tokens.sv
// Multi-lane serial token multiplier. Each '1' on a[i] becomes factor '1's
// on b[i], released under b_ready[i] back-pressure.
//   clk, rst   clock / synchronous active-high reset
//   tok        token bus (slave side): factor, a, b_ready in; b, overflow,
//              any_ovf out
// MAX_PENDING must not exceed multiply_tokens_pkg::DEF_MAX_PENDING, which
// sizes the per-lane counters.
module multiply_tokens
  import multiply_tokens_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int FACTOR_W    = 3,
  parameter int MAX_PENDING = 255
) (
  input  logic               clk,
  input  logic               rst,
  multiply_tokens_if.slave   tok
);

  lane_in_t  [LANES-1:0] din;
  lane_out_t [LANES-1:0] dout;
  logic      [LANES-1:0] ovf;
  logic                  any_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign din[i].a       = tok.a[i];
    assign din[i].b_ready = tok.b_ready[i];
    assign tok.b[i]       = dout[i].b;
    assign ovf[i]         = dout[i].ovf;

    multiply_tokens_lane #(
      .FACTOR_W    (FACTOR_W),
      .MAX_PENDING (MAX_PENDING)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .factor (tok.factor),
      .din    (din[i]),
      .dout   (dout[i])
    );
  end

  // Reduced from the already-registered flags, so it trails them by a cycle.
  always_ff @(posedge clk) begin
    if (rst) any_q <= 1'b0;
    else     any_q <= |ovf;
  end

  assign tok.overflow = ovf;
  assign tok.any_ovf  = any_q;

endmodule
